// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the memory access sequencer.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } mau_state_t;

   localparam int MEM_TIMEOUT_DEFAULT = 255;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;

endpackage

// File: rtl/mau_timeout_cnt.sv
// Wait-cycle counter for an outstanding bus request.
// `expired` is high during the TIMEOUT-th consecutive ack-less cycle.
module mau_timeout_cnt
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q holds the number of ack-less cycles already completed.
   assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && !expired)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_access_unit.sv
// Sequences controller memory intent into a req/ack bus access, stalling via clk_en (latency 2+N).
// Owns IR/MDR; optional request watchdog and sticky bus_err under MEM_TIMEOUT_EN.
module mem_access_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_en,
   input  logic              iord,
   input  logic              mem_write,
   input  logic              ir_write,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] alu_out,
   input  logic [DATA_W-1:0] wdata,
   output logic              clk_en,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ir,
   output logic [5:0]        opcode,
   output logic [5:0]        funct,
   output logic [DATA_W-1:0] mdr,
   output logic              bus_err
);

   mau_state_t        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;

`ifdef MEM_TIMEOUT_EN
   logic bus_err_q, bus_err_d;
   logic cnt_expired;

   mau_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == IDLE),
      .en      ((state_q == REQ) && !mem_ack),
      .expired (cnt_expired)
   );

   assign bus_err = bus_err_q;
`else
   assign bus_err = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ir_d        = ir_q;
      mdr_d       = mdr_q;
      clk_en      = 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_d   = bus_err_q;
`endif
      case (state_q)
         IDLE: begin
            clk_en = !mem_en;
            if (mem_en) begin
               mem_addr_d  = iord ? alu_out : pc;
               mem_wdata_d = wdata;
               mem_we_d    = mem_write;
               mem_req_d   = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            // The latched write strobe, not the live input, decides read vs store.
            if (mem_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (!mem_we_q) begin
                  if (ir_write)
                     ir_d = mem_rdata;
                  else
                     mdr_d = mem_rdata;
               end
               state_d = DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_expired) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               bus_err_d = 1'b1;
               state_d   = ERR;
            end
`endif
         end
         DONE: begin
            clk_en  = 1'b1;
            state_d = IDLE;
         end
`ifdef MEM_TIMEOUT_EN
         ERR: begin
            clk_en = 1'b0;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ir_q        <= '0;
         mdr_q       <= '0;
`ifdef MEM_TIMEOUT_EN
         bus_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ir_q        <= ir_d;
         mdr_q       <= mdr_d;
`ifdef MEM_TIMEOUT_EN
         bus_err_q   <= bus_err_d;
`endif
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign ir        = ir_q;
   assign mdr       = mdr_q;
   assign opcode    = ir_q[OPCODE_MSB:OPCODE_LSB];
   assign funct     = ir_q[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-cycle vector table plus watchdog and reset corner cases.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en, iord, mem_write, ir_write;
   logic [31:0] pc, alu_out, wdata;
   logic        clk_en, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata, ir, mdr;
   logic [5:0]  opcode, funct;
   logic        bus_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_unit #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_en    (mem_en),
      .iord      (iord),
      .mem_write (mem_write),
      .ir_write  (ir_write),
      .pc        (pc),
      .alu_out   (alu_out),
      .wdata     (wdata),
      .clk_en    (clk_en),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ir        (ir),
      .opcode    (opcode),
      .funct     (funct),
      .mdr       (mdr),
      .bus_err   (bus_err)
   );

   typedef struct packed {
      logic        en, iord, mw, irw;
      logic [31:0] pc, alu, wd;
      logic        ack;
      logic [31:0] rd;
      logic        e_ce, e_req, e_we;
      logic [31:0] e_addr, e_wd, e_ir, e_mdr;
      logic [5:0]  e_op, e_fn;
   } vec_t;

   localparam logic [31:0] P  = 32'h0040_0000;
   localparam logic [31:0] I  = 32'h0109_4020;
   localparam logic [31:0] A  = 32'h1000_0004;
   localparam logic [31:0] B  = 32'h1000_0008;
   localparam logic [31:0] D  = 32'hDEAD_BEEF;
   localparam logic [31:0] S  = 32'h1234_5678;
   localparam logic [31:0] BD = 32'hBAD0_BAD0;

   vec_t vec [21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic io, input logic mw, input logic irw,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] wd,
                        input logic ack, input logic [31:0] rd);
      @(negedge clk);
      mem_en = en; iord = io; mem_write = mw; ir_write = irw;
      pc = p; alu_out = a; wdata = wd; mem_ack = ack; mem_rdata = rd;
      #1;
   endtask

   initial begin
      //            en io mw irw pc      alu           wdata ack rdata         ce req we addr wdata ir mdr op     fn
      vec[0]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1,1'b0,1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 6'h0, 6'h00};
      vec[1]  = '{1'b1,1'b0,1'b0,1'b1, P,     32'h0, 32'h0, 1'b0, 32'h0,        1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 6'h0, 6'h00};
      vec[2]  = '{1'b1,1'b0,1'b0,1'b1, P,     32'h0, 32'h0, 1'b1, I,            1'b0,1'b1,1'b0, P,     32'h0, 32'h0, 32'h0, 6'h0, 6'h00};
      vec[3]  = '{1'b1,1'b0,1'b0,1'b1, P,     32'h0, 32'h0, 1'b0, 32'h0,        1'b1,1'b0,1'b0, P,     32'h0, I,     32'h0, 6'h0, 6'h20};
      vec[4]  = '{1'b0,1'b0,1'b0,1'b0, P+4,   32'h0, 32'h0, 1'b0, 32'h0,        1'b1,1'b0,1'b0, P,     32'h0, I,     32'h0, 6'h0, 6'h20};
      vec[5]  = '{1'b1,1'b1,1'b0,1'b0, P+4,   A,     32'h0, 1'b0, 32'h0,        1'b0,1'b0,1'b0, P,     32'h0, I,     32'h0, 6'h0, 6'h20};
      vec[6]  = '{1'b1,1'b1,1'b0,1'b0, P+8,   32'hFFFF_FFF0, 32'h0, 1'b0, 32'h0,1'b0,1'b1,1'b0, A,     32'h0, I,     32'h0, 6'h0, 6'h20};
      vec[7]  = '{1'b1,1'b1,1'b0,1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0,1'b1,1'b0, A,     32'h0, I,     32'h0, 6'h0, 6'h20};
      vec[8]  = '{1'b1,1'b1,1'b0,1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0,1'b1,1'b0, A,     32'h0, I,     32'h0, 6'h0, 6'h20};
      vec[9]  = '{1'b1,1'b1,1'b0,1'b0, 32'h0, 32'h0, 32'h0, 1'b1, D,            1'b0,1'b1,1'b0, A,     32'h0, I,     32'h0, 6'h0, 6'h20};
      vec[10] = '{1'b1,1'b1,1'b0,1'b0, 32'h0, A,     32'h0, 1'b0, 32'h0,        1'b1,1'b0,1'b0, A,     32'h0, I,     D,     6'h0, 6'h20};
      vec[11] = '{1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1,1'b0,1'b0, A,     32'h0, I,     D,     6'h0, 6'h20};
      vec[12] = '{1'b1,1'b1,1'b1,1'b0, 32'h0, B,     S,     1'b0, 32'h0,        1'b0,1'b0,1'b0, A,     32'h0, I,     D,     6'h0, 6'h20};
      vec[13] = '{1'b1,1'b1,1'b1,1'b0, 32'h0, B,     S,     1'b0, 32'h0,        1'b0,1'b1,1'b1, B,     S,     I,     D,     6'h0, 6'h20};
      vec[14] = '{1'b1,1'b1,1'b1,1'b0, 32'h0, B,     32'h0, 1'b1, 32'hCAFE_F00D,1'b0,1'b1,1'b1, B,     S,     I,     D,     6'h0, 6'h20};
      vec[15] = '{1'b1,1'b1,1'b1,1'b0, 32'h0, B,     32'h0, 1'b0, 32'h0,        1'b1,1'b0,1'b0, B,     S,     I,     D,     6'h0, 6'h20};
      vec[16] = '{1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1,1'b0,1'b0, B,     S,     I,     D,     6'h0, 6'h20};
      vec[17] = '{1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0, 32'h0, 1'b1, BD,           1'b1,1'b0,1'b0, B,     S,     I,     D,     6'h0, 6'h20};
      vec[18] = '{1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1,1'b0,1'b0, B,     S,     I,     D,     6'h0, 6'h20};
      vec[19] = '{1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h0, 1'b1, BD,           1'b1,1'b0,1'b0, B,     S,     I,     D,     6'h0, 6'h20};
      vec[20] = '{1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1,1'b0,1'b0, B,     S,     I,     D,     6'h0, 6'h20};

      rst = 1'b1;
      mem_en = 1'b0; iord = 1'b0; mem_write = 1'b0; ir_write = 1'b0;
      pc = '0; alu_out = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

      // Reset state, with clk_en following mem_en through the IDLE rule.
      @(negedge clk); #1;
      chk("rst clk_en idle", clk_en, 1'b1);
      chk("rst mem_req", mem_req, 1'b0);
      chk("rst mem_we", mem_we, 1'b0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      chk("rst ir", ir, 32'h0);
      chk("rst mdr", mdr, 32'h0);
      chk("rst opcode", opcode, 6'h0);
      chk("rst funct", funct, 6'h0);
      chk("rst bus_err", bus_err, 1'b0);
      mem_en = 1'b1; #1;
      chk("rst clk_en mem_en", clk_en, 1'b0);
      @(negedge clk);
      mem_en = 1'b0;
      rst = 1'b0;

      // Fetch, load with 3 waits, store, then 5 idle cycles with stray acks.
      for (int i = 0; i < 21; i++) begin
         drive(vec[i].en, vec[i].iord, vec[i].mw, vec[i].irw,
               vec[i].pc, vec[i].alu, vec[i].wd, vec[i].ack, vec[i].rd);
         chk($sformatf("row%0d clk_en", i), clk_en, vec[i].e_ce);
         chk($sformatf("row%0d mem_req", i), mem_req, vec[i].e_req);
         chk($sformatf("row%0d mem_we", i), mem_we, vec[i].e_we);
         chk($sformatf("row%0d mem_addr", i), mem_addr, vec[i].e_addr);
         chk($sformatf("row%0d mem_wdata", i), mem_wdata, vec[i].e_wd);
         chk($sformatf("row%0d ir", i), ir, vec[i].e_ir);
         chk($sformatf("row%0d mdr", i), mdr, vec[i].e_mdr);
         chk($sformatf("row%0d opcode", i), opcode, vec[i].e_op);
         chk($sformatf("row%0d funct", i), funct, vec[i].e_fn);
      end

`ifdef MEM_TIMEOUT_EN
      // Ack-less request: four REQ cycles, then sticky ERR until reset.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000_0000, 32'h0, 1'b0, 32'h0);
      chk("to idle clk_en", clk_en, 1'b0);
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000_0000, 32'h0, 1'b0, 32'h0);
         chk($sformatf("to req%0d mem_req", k), mem_req, 1'b1);
         chk($sformatf("to req%0d bus_err", k), bus_err, 1'b0);
         chk($sformatf("to req%0d clk_en", k), clk_en, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000_0000, 32'h0, (k == 1), 32'h7777_7777);
         chk($sformatf("err%0d bus_err", k), bus_err, 1'b1);
         chk($sformatf("err%0d mem_req", k), mem_req, 1'b0);
         chk($sformatf("err%0d clk_en", k), clk_en, 1'b0);
         chk($sformatf("err%0d mdr", k), mdr, D);
      end
      @(negedge clk);
      rst = 1'b1; mem_en = 1'b0; mem_ack = 1'b0; #1;
      chk("err rst bus_err", bus_err, 1'b0);
      chk("err rst clk_en", clk_en, 1'b1);
      @(negedge clk);
      rst = 1'b0;
`else
      // Without the watchdog, a slow memory simply stretches REQ.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000_0000, 32'h0, 1'b0, 32'h0);
      chk("wait idle clk_en", clk_en, 1'b0);
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000_0000, 32'h0, 1'b0, 32'h0);
         chk($sformatf("wait%0d mem_req", k), mem_req, 1'b1);
         chk($sformatf("wait%0d clk_en", k), clk_en, 1'b0);
         chk($sformatf("wait%0d bus_err", k), bus_err, 1'b0);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000_0000, 32'h0, 1'b1, 32'h55AA_55AA);
      chk("wait ack mem_req", mem_req, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000_0000, 32'h0, 1'b0, 32'h0);
      chk("wait done clk_en", clk_en, 1'b1);
      chk("wait done mdr", mdr, 32'h55AA_55AA);
      chk("wait done ir", ir, I);
      chk("wait done addr", mem_addr, 32'h2000_0000);
`endif

      // Reset in the second REQ cycle abandons the fetch; a late ack is ignored.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 32'hAABB_CCDD);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("pre ir", ir, 32'hAABB_CCDD);
      chk("pre opcode", opcode, 6'h2A);
      chk("pre funct", funct, 6'h1D);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'h0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("mid req1 mem_req", mem_req, 1'b1);
      chk("mid req1 mem_addr", mem_addr, 32'h0000_0104);
      @(negedge clk);
      rst = 1'b1; #1;
      chk("mid rst mem_req", mem_req, 1'b0);
      chk("mid rst ir", ir, 32'h0);
      chk("mid rst mem_addr", mem_addr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      mem_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111; #1;
      chk("late ack mem_req", mem_req, 1'b0);
      chk("late ack clk_en", clk_en, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("late ack ir", ir, 32'h0);
      chk("late ack mdr", mdr, 32'h0);
      chk("late ack mem_req2", mem_req, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
